ws2812_frame_sched: RTL and testbench

- Controller in front of the WS2812 serializer. It owns the write port of a double-banked LED word memory. SPI host writes and an internal fill engine share that port through a fixed-priority arbiter.
- It paces the serializer with a fixed frame period and issues a one-cycle frame_start.
- It swaps the displayed bank only at frame boundaries, so a frame is never torn.
- Sits between the SPI slave and the ws2812 output engine.

---
 rtl/ws2812_pkg.sv | 12 +
 rtl/ws2812_fill_engine.sv | 69 ++++++
 rtl/ws2812_frame_sched.sv | 152 +++++++++++++++
 tb/tb_ws2812_frame_sched.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared constants and state encodings for the WS2812 frame scheduler.
package ws2812_pkg;

    localparam int unsigned WORD_COUNT   = 1305;
    localparam int unsigned ADDR_W       = 13;
    localparam int unsigned FRAME_CYCLES = 800000;
    localparam int unsigned TIMER_W      = 20;

    typedef enum logic {S_WAIT, S_ISSUE} sched_state_e;
    typedef enum logic {F_IDLE, F_RUN}   fill_state_e;

endpackage

// File: rtl/ws2812_fill_engine.sv
// Back-bank fill engine: writes one constant word to every address, stalling while
// the host owns the write port.
module ws2812_fill_engine
    import ws2812_pkg::*;
#(
    parameter int unsigned WORD_COUNT = ws2812_pkg::WORD_COUNT,
    parameter int unsigned ADDR_W     = ws2812_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       value,
    input  logic              stall,
    output logic              busy,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       value_q, value_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        value_d = value_q;
        req     = 1'b0;
        unique case (state_q)
            F_IDLE: begin
                if (start) begin
                    value_d = value;
                    addr_d  = '0;
                    state_d = F_RUN;
                end
            end
            F_RUN: begin
                // A stalled cycle holds the address so nothing is skipped.
                if (!stall) begin
                    req = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = F_IDLE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= F_IDLE;
            addr_q  <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            value_q <= value_d;
        end
    end

    assign busy = (state_q == F_RUN);
    assign addr = addr_q;
    assign data = value_q;

endmodule

// File: rtl/ws2812_frame_sched.sv
// Frame scheduler and back-bank write arbiter in front of the WS2812 serializer.
// Define LATE_FRAME_CNT_EN to build the saturating late-frame counter.
module ws2812_frame_sched
    import ws2812_pkg::*;
#(
    parameter int unsigned WORD_COUNT   = ws2812_pkg::WORD_COUNT,
    parameter int unsigned ADDR_W       = ws2812_pkg::ADDR_W,
    parameter int unsigned FRAME_CYCLES = ws2812_pkg::FRAME_CYCLES,
    parameter int unsigned TIMER_W      = ws2812_pkg::TIMER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       spi_data,
    input  logic [ADDR_W-1:0] spi_address,
    input  logic              spi_write_strobe,
    input  logic              host_commit,
    input  logic              fill_start,
    input  logic [15:0]       fill_value,
    input  logic              out_busy,
    output logic              mem_we,
    output logic              mem_bank,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [15:0]       mem_wdata,
    output logic              frame_start,
    output logic              rd_bank,
    output logic              commit_pending,
    output logic              fill_busy,
    output logic              addr_err,
    output logic [7:0]        late_frames
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(WORD_COUNT - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME_CYCLES - 1);

    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic [15:0]       fill_data;
    logic              spi_valid;

    sched_state_e       sched_q, sched_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               issue;
    logic               swap;
    logic               rd_bank_q, commit_q;

    logic              mem_we_q, mem_bank_q, addr_err_q;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [15:0]       mem_wdata_q;

    ws2812_fill_engine #(
        .WORD_COUNT(WORD_COUNT),
        .ADDR_W    (ADDR_W)
    ) u_fill (
        .clk  (clk),
        .rst  (rst),
        .start(fill_start),
        .value(fill_value),
        .stall(spi_write_strobe),
        .busy (fill_busy),
        .req  (fill_req),
        .addr (fill_addr),
        .data (fill_data)
    );

    assign spi_valid = spi_write_strobe && (spi_address <= LAST_ADDR);

    // When the serializer is idle the frame issues straight from the last wait
    // cycle, keeping the period at exactly FRAME_CYCLES.
    always_comb begin
        sched_d = sched_q;
        timer_d = timer_q;
        issue   = 1'b0;
        unique case (sched_q)
            S_WAIT: begin
                if (timer_q == TIMER_LAST) begin
                    if (out_busy) begin
                        sched_d = S_ISSUE;
                    end else begin
                        issue   = 1'b1;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_ISSUE: begin
                if (!out_busy) begin
                    issue   = 1'b1;
                    timer_d = '0;
                    sched_d = S_WAIT;
                end
            end
        endcase
    end

    assign frame_start    = issue && !rst;
    assign swap           = frame_start && commit_q && !fill_busy;
    assign rd_bank        = rd_bank_q ^ swap;
    assign commit_pending = commit_q && !swap;

    always_ff @(posedge clk) begin
        if (rst) begin
            sched_q     <= S_WAIT;
            timer_q     <= '0;
            rd_bank_q   <= 1'b0;
            commit_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_bank_q  <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            sched_q    <= sched_d;
            timer_q    <= timer_d;
            rd_bank_q  <= rd_bank;
            commit_q   <= commit_pending || host_commit;
            mem_we_q   <= spi_valid || fill_req;
            mem_bank_q <= ~rd_bank;
            addr_err_q <= spi_write_strobe && !spi_valid;
            if (spi_valid) begin
                mem_waddr_q <= spi_address;
                mem_wdata_q <= spi_data;
            end else if (fill_req) begin
                mem_waddr_q <= fill_addr;
                mem_wdata_q <= fill_data;
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_bank  = mem_bank_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign addr_err  = addr_err_q;

`ifdef LATE_FRAME_CNT_EN
    logic [7:0] late_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            late_q <= '0;
        end else if (frame_start && sched_q == S_ISSUE && late_q != 8'hFF) begin
            late_q <= late_q + 8'd1;
        end
    end

    assign late_frames = late_q;
`else
    assign late_frames = 8'd0;
`endif

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed self-checking bench for ws2812_frame_sched with a 100-cycle frame period.
module tb_ws2812_frame_sched;

    localparam int unsigned FC = 100;
    localparam int unsigned WC = 1305;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] spi_data;
    logic [12:0] spi_address;
    logic        spi_write_strobe;
    logic        host_commit;
    logic        fill_start;
    logic [15:0] fill_value;
    logic        out_busy;
    logic        mem_we;
    logic        mem_bank;
    logic [12:0] mem_waddr;
    logic [15:0] mem_wdata;
    logic        frame_start;
    logic        rd_bank;
    logic        commit_pending;
    logic        fill_busy;
    logic        addr_err;
    logic [7:0]  late_frames;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ws2812_frame_sched #(
        .FRAME_CYCLES(FC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .spi_data        (spi_data),
        .spi_address     (spi_address),
        .spi_write_strobe(spi_write_strobe),
        .host_commit     (host_commit),
        .fill_start      (fill_start),
        .fill_value      (fill_value),
        .out_busy        (out_busy),
        .mem_we          (mem_we),
        .mem_bank        (mem_bank),
        .mem_waddr       (mem_waddr),
        .mem_wdata       (mem_wdata),
        .frame_start     (frame_start),
        .rd_bank         (rd_bank),
        .commit_pending  (commit_pending),
        .fill_busy       (fill_busy),
        .addr_err        (addr_err),
        .late_frames     (late_frames)
    );

    typedef struct {
        logic        strobe;
        logic [12:0] addr;
        logic [15:0] data;
        logic        exp_we;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        spi_write_strobe = 1'b0;
        spi_address      = '0;
        spi_data         = '0;
        host_commit      = 1'b0;
        fill_start       = 1'b0;
        fill_value       = '0;
        out_busy         = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Returns positioned in the cycle where frame_start is high.
    task automatic wait_frame(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (frame_start) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_fill(input logic [15:0] val, input bit contend, input string tag);
        int exp_addr = 0;
        int busy_cyc = 0;
        int bad = 0;
        int spi_cnt = 0;
        int first_we = -1;
        int last_we = -1;
        fill_value = val;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        check({tag, "_busy_on"}, fill_busy, 1);
        for (int c = 0; c < 1320; c++) begin
            if (fill_busy) busy_cyc++;
            if (mem_we) begin
                if (contend && mem_wdata == 16'hBEEF && mem_waddr == 13'd7) begin
                    spi_cnt++;
                end else begin
                    if (mem_waddr !== 13'(exp_addr) || mem_wdata !== val) bad++;
                    exp_addr++;
                end
                if (first_we < 0) first_we = c;
                last_we = c;
            end
            // A second fill_start mid-run must be ignored.
            fill_start = (c == 20);
            fill_value = (c == 20) ? 16'h5555 : val;
            spi_write_strobe = contend && (c == 10 || c == 11 || c == 700);
            spi_address      = 13'd7;
            spi_data         = 16'hBEEF;
            tick();
        end
        spi_write_strobe = 1'b0;
        fill_start       = 1'b0;
        check({tag, "_busy_cycles"}, busy_cyc, contend ? WC + 3 : WC);
        check({tag, "_fill_writes"}, exp_addr, WC);
        check({tag, "_bad_writes"}, bad, 0);
        check({tag, "_busy_off"}, fill_busy, 0);
        if (contend) check({tag, "_spi_writes"}, spi_cnt, 3);
        else check({tag, "_write_span"}, last_we - first_we + 1, WC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        bit   found;
        int   wr_cnt;
        logic exp_late;

        vecs[0] = '{1'b1, 13'd5,    16'h1234, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 13'd1305, 16'hDEAD, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 13'd0,    16'h0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 13'd1304, 16'hCAFE, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 13'd0,    16'h0001, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 13'd8191, 16'hFFFF, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 13'd0,    16'h0000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 13'd4096, 16'h4242, 1'b0, 1'b1};

        // Reset state
        do_reset();
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_bank", mem_bank, 0);
        check("rst_mem_waddr", mem_waddr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_rd_bank", rd_bank, 0);
        check("rst_commit_pending", commit_pending, 0);
        check("rst_fill_busy", fill_busy, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_late_frames", late_frames, 0);

        // Host write vectors
        for (int i = 0; i < 8; i++) begin
            spi_write_strobe = vecs[i].strobe;
            spi_address      = vecs[i].addr;
            spi_data         = vecs[i].data;
            tick();
            spi_write_strobe = 1'b0;
            check($sformatf("vec%0d_we", i), mem_we, vecs[i].exp_we);
            check($sformatf("vec%0d_err", i), addr_err, vecs[i].exp_err);
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_waddr", i), mem_waddr, vecs[i].addr);
                check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].data);
                check($sformatf("vec%0d_bank", i), mem_bank, 1);
            end
        end
        tick();
        check("err_one_cycle", addr_err, 0);

        // Frame pacing with an idle serializer
        do_reset();
        for (int c = 1; c <= 3 * FC; c++) begin
            check($sformatf("frame_c%0d", c), frame_start, (c % FC) == 0);
            tick();
        end

        // Late frame: serializer busy across the timer expiry
        do_reset();
        out_busy = 1'b1;
        for (int c = 1; c < 140; c++) begin
            check($sformatf("late_c%0d", c), frame_start, 0);
            tick();
        end
        out_busy = 1'b0;
        #1;
        check("late_issue", frame_start, 1);
        tick();
`ifdef LATE_FRAME_CNT_EN
        exp_late = 1'b1;
`else
        exp_late = 1'b0;
`endif
        check("late_frames", late_frames, {7'd0, exp_late});
        for (int c = 141; c <= 240; c++) begin
            check($sformatf("late_next_c%0d", c), frame_start, c == 240);
            tick();
        end

        // Fill engine, uncontended then with three host writes mid-fill
        do_reset();
        run_fill(16'h00FF, 1'b0, "fill");
        check("fill_bank", mem_bank, 1);
        run_fill(16'hA5A5, 1'b1, "fill_spi");

        // Commit deferred by a running fill
        do_reset();
        fill_value = 16'h1111;
        fill_start = 1'b1;
        tick();
        fill_start  = 1'b0;
        host_commit = 1'b1;
        tick();
        host_commit = 1'b0;
        check("commit_set", commit_pending, 1);
        check("commit_rd_bank0", rd_bank, 0);
        for (int c = 0; c < 1400 && fill_busy; c++) begin
            if (frame_start) check("commit_deferred", rd_bank, 0);
            tick();
        end
        check("commit_still_pending", commit_pending, 1);
        check("commit_rd_bank_held", rd_bank, 0);
        wait_frame(FC + 10, found);
        check("commit_frame_found", found, 1);
        check("commit_swap_bank", rd_bank, 1);
        check("commit_swap_clear", commit_pending, 0);
        // Commit in the frame_start cycle applies one frame later
        host_commit = 1'b1;
        tick();
        host_commit = 1'b0;
        check("late_commit_pending", commit_pending, 1);
        check("late_commit_bank", rd_bank, 1);
        wait_frame(FC + 10, found);
        check("late_commit_found", found, 1);
        check("late_commit_swap", rd_bank, 0);
        check("late_commit_clear", commit_pending, 0);
        tick();
        host_commit = 1'b1;
        tick();
        host_commit = 1'b0;
        wait_frame(FC + 10, found);
        check("third_commit_found", found, 1);
        check("third_commit_swap", rd_bank, 1);
        tick();
        spi_write_strobe = 1'b1;
        spi_address      = 13'd3;
        spi_data         = 16'h0303;
        tick();
        spi_write_strobe = 1'b0;
        check("back_bank_we", mem_we, 1);
        check("back_bank_sel", mem_bank, 0);

        // Reset mid-fill with a commit pending and rd_bank=1
        fill_value = 16'h2222;
        fill_start = 1'b1;
        tick();
        fill_start  = 1'b0;
        host_commit = 1'b1;
        tick();
        host_commit = 1'b0;
        for (int c = 0; c < 50; c++) tick();
        check("pre_rst_busy", fill_busy, 1);
        check("pre_rst_pending", commit_pending, 1);
        check("pre_rst_we", mem_we, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_busy", fill_busy, 0);
        check("mid_rst_pending", commit_pending, 0);
        check("mid_rst_rd_bank", rd_bank, 0);
        check("mid_rst_frame", frame_start, 0);
        wr_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (mem_we) wr_cnt++;
            tick();
        end
        check("post_rst_writes", wr_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
